mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_select.sv | 53 +++++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_types
// Shared types for the instruction/data memory arbiter:
//   arb_state_t : arbiter FSM states
//   arb_grant_t : result of the combinational request picker
//   arb_op_t    : latched downstream operation
// Optional build macro used by the arbiter: MEM_ARBITER_RR_EN
// -----------------------------------------------------------------------------
package mem_arbiter_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_I    = 2'd1,
        GRANT_D    = 2'd2
    } arb_grant_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

endpackage : mem_arbiter_types

// File: rtl/mem_arbiter_select.sv
// -----------------------------------------------------------------------------
// arb_select
// Combinational picker deciding which requester is granted from IDLE.
//   inst_req   : instruction read pending
//   data_req   : data read or write pending
//   last_grant : previous grant (0 = inst, 1 = data); used only when
//                MEM_ARBITER_RR_EN is defined
//   grant      : GRANT_NONE / GRANT_I / GRANT_D
// Build macro: MEM_ARBITER_RR_EN selects round-robin on contention;
// otherwise data has fixed priority (the MEM-stage instruction is older).
// -----------------------------------------------------------------------------
module arb_select
    import mem_arbiter_types::*;
(
    input  logic       inst_req,
    input  logic       data_req,
    input  logic       last_grant,
    output arb_grant_t grant
);

`ifdef MEM_ARBITER_RR_EN
    // Round-robin: on contention grant whichever side was not served last.
    always_comb begin
        grant = GRANT_NONE;
        if (inst_req && data_req) begin
            grant = last_grant ? GRANT_I : GRANT_D;
        end else if (data_req) begin
            grant = GRANT_D;
        end else if (inst_req) begin
            grant = GRANT_I;
        end else begin
            grant = GRANT_NONE;
        end
    end
`else
    // last_grant is irrelevant with fixed priority.
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;

    // Fixed priority: data first, then instruction.
    always_comb begin
        grant = GRANT_NONE;
        if (data_req) begin
            grant = GRANT_D;
        end else if (inst_req) begin
            grant = GRANT_I;
        end else begin
            grant = GRANT_NONE;
        end
    end
`endif

endmodule : arb_select

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Multiplexes the pipeline's instruction and data memory requesters onto one
// single-ported physical memory interface; one transaction outstanding.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   inst_mem_read/address         : instruction read request (held until resp)
//   inst_mem_rdata/resp           : instruction completion (resp = 1-cycle pulse)
//   data_mem_read/write/address/
//   wdata/mbe                     : data request (held until resp)
//   data_mem_rdata/resp           : data completion (resp = 1-cycle pulse)
//   pmem_read/write/address/
//   wdata/mbe                     : downstream request, driven from registers only
//   pmem_rdata/resp               : downstream completion
// Build macro: MEM_ARBITER_RR_EN enables round-robin arbitration with a
// last_grant register; undefined gives fixed data priority.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_types::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int MBE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_mem_read,
    input  logic [ADDR_W-1:0] inst_mem_address,
    output logic [DATA_W-1:0] inst_mem_rdata,
    output logic              inst_mem_resp,
    input  logic              data_mem_read,
    input  logic              data_mem_write,
    input  logic [ADDR_W-1:0] data_mem_address,
    input  logic [DATA_W-1:0] data_mem_wdata,
    input  logic [MBE_W-1:0]  data_mem_mbe,
    output logic [DATA_W-1:0] data_mem_rdata,
    output logic              data_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    output logic [MBE_W-1:0]  pmem_mbe,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MBE_W-1:0]  mbe_q, mbe_d;
    arb_op_t           op_q, op_d;
    arb_grant_t        grant_s;
    logic              last_grant_s;
    logic              data_req_s;

    assign data_req_s = data_mem_read | data_mem_write;

`ifdef MEM_ARBITER_RR_EN
    logic last_grant_q, last_grant_d;
    assign last_grant_s = last_grant_q;
`else
    assign last_grant_s = 1'b0;
`endif

    arb_select u_arb_select (
        .inst_req   (inst_mem_read),
        .data_req   (data_req_s),
        .last_grant (last_grant_s),
        .grant      (grant_s)
    );

    // Next-state and grant latching; requester inputs are sampled only in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mbe_d   = mbe_q;
        op_d    = op_q;
`ifdef MEM_ARBITER_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                case (grant_s)
                    GRANT_D: begin
                        state_d = SERVE_D;
                        addr_d  = data_mem_address;
                        wdata_d = data_mem_wdata;
                        mbe_d   = data_mem_mbe;
                        // read+write together is treated as a write
                        op_d    = data_mem_write ? OP_WRITE : OP_READ;
`ifdef MEM_ARBITER_RR_EN
                        last_grant_d = 1'b1;
`endif
                    end
                    GRANT_I: begin
                        state_d = SERVE_I;
                        addr_d  = inst_mem_address;
                        wdata_d = {DATA_W{1'b0}};
                        mbe_d   = {MBE_W{1'b1}};
                        op_d    = OP_READ;
`ifdef MEM_ARBITER_RR_EN
                        last_grant_d = 1'b0;
`endif
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            SERVE_I, SERVE_D: begin
                // Always pass through IDLE so a held request is a new one.
                if (pmem_resp) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            mbe_q   <= {MBE_W{1'b0}};
            op_q    <= OP_READ;
`ifdef MEM_ARBITER_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mbe_q   <= mbe_d;
            op_q    <= op_d;
`ifdef MEM_ARBITER_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Downstream side depends only on registered state.
    assign pmem_read    = (state_q != IDLE) && (op_q == OP_READ);
    assign pmem_write   = (state_q != IDLE) && (op_q == OP_WRITE);
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign pmem_mbe     = mbe_q;

    // Completion is same-cycle with pmem_resp; pmem_resp in IDLE is dropped.
    assign inst_mem_resp  = (state_q == SERVE_I) && pmem_resp;
    assign data_mem_resp  = (state_q == SERVE_D) && pmem_resp;
    assign inst_mem_rdata = inst_mem_resp ? pmem_rdata : {DATA_W{1'b0}};
    assign data_mem_rdata = data_mem_resp ? pmem_rdata : {DATA_W{1'b0}};

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter (default fixed-priority build). Inputs are
// driven 1 ns after the rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_mem_read;
    logic [31:0] inst_mem_address;
    logic [31:0] inst_mem_rdata;
    logic        inst_mem_resp;
    logic        data_mem_read;
    logic        data_mem_write;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic [3:0]  data_mem_mbe;
    logic [31:0] data_mem_rdata;
    logic        data_mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_mbe;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    int tests_run;
    int tests_failed;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_mem_read    (inst_mem_read),
        .inst_mem_address (inst_mem_address),
        .inst_mem_rdata   (inst_mem_rdata),
        .inst_mem_resp    (inst_mem_resp),
        .data_mem_read    (data_mem_read),
        .data_mem_write   (data_mem_write),
        .data_mem_address (data_mem_address),
        .data_mem_wdata   (data_mem_wdata),
        .data_mem_mbe     (data_mem_mbe),
        .data_mem_rdata   (data_mem_rdata),
        .data_mem_resp    (data_mem_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_mbe         (pmem_mbe),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        rst              = 1'b1;
        inst_mem_read    = 1'b0;
        inst_mem_address = 32'h0;
        data_mem_read    = 1'b0;
        data_mem_write   = 1'b0;
        data_mem_address = 32'h0;
        data_mem_wdata   = 32'h0;
        data_mem_mbe     = 4'h0;
        pmem_rdata       = 32'h0;
        pmem_resp        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sample();
        check_val("rst_pmem_read",  {63'd0, pmem_read},  64'd0);
        check_val("rst_pmem_write", {63'd0, pmem_write}, 64'd0);
        check_val("rst_pmem_addr",  {32'd0, pmem_address}, 64'd0);
        check_val("rst_pmem_mbe",   {60'd0, pmem_mbe},   64'd0);
        check_val("rst_i_resp",     {63'd0, inst_mem_resp}, 64'd0);
        check_val("rst_d_resp",     {63'd0, data_mem_resp}, 64'd0);

        // ---- instruction-only read, pmem_resp 3 cycles after request ----
        tick();
        inst_mem_read    = 1'b1;
        inst_mem_address = 32'h0000_0100;
        sample();
        check_val("i_idle_no_pmem", {63'd0, pmem_read}, 64'd0);
        tick();
        sample();
        check_val("i_pmem_read", {63'd0, pmem_read}, 64'd1);
        check_val("i_pmem_addr", {32'd0, pmem_address}, 64'h100);
        check_val("i_pmem_mbe",  {60'd0, pmem_mbe}, 64'hF);
        check_val("i_no_resp_yet", {63'd0, inst_mem_resp}, 64'd0);
        tick();
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h00A0_0093;
        sample();
        check_val("i_resp",       {63'd0, inst_mem_resp}, 64'd1);
        check_val("i_rdata",      {32'd0, inst_mem_rdata}, 64'h00A0_0093);
        check_val("i_d_resp_off", {63'd0, data_mem_resp}, 64'd0);
        check_val("i_d_rdata_off", {32'd0, data_mem_rdata}, 64'd0);
        tick();
        inst_mem_read = 1'b0;
        pmem_resp     = 1'b0;
        sample();
        check_val("i_done_resp", {63'd0, inst_mem_resp}, 64'd0);
        check_val("i_done_read", {63'd0, pmem_read}, 64'd0);

        // ---- simultaneous requests: data first, IDLE gap, then inst ----
        tick();
        inst_mem_read    = 1'b1;
        inst_mem_address = 32'h0000_0104;
        data_mem_read    = 1'b1;
        data_mem_address = 32'h0000_2000;
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h1111_2222;
        sample();
        check_val("s_first_addr",  {32'd0, pmem_address}, 64'h2000);
        check_val("s_first_read",  {63'd0, pmem_read}, 64'd1);
        check_val("s_d_resp",      {63'd0, data_mem_resp}, 64'd1);
        check_val("s_d_rdata",     {32'd0, data_mem_rdata}, 64'h1111_2222);
        check_val("s_i_resp_off",  {63'd0, inst_mem_resp}, 64'd0);
        tick();
        data_mem_read = 1'b0;
        pmem_resp     = 1'b0;
        sample();
        check_val("s_gap_read", {63'd0, pmem_read}, 64'd0);
        tick();
        sample();
        check_val("s_second_addr", {32'd0, pmem_address}, 64'h104);
        check_val("s_second_read", {63'd0, pmem_read}, 64'd1);
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h3333_4444;
        #1;
        check_val("s_i_resp",     {63'd0, inst_mem_resp}, 64'd1);
        check_val("s_i_rdata",    {32'd0, inst_mem_rdata}, 64'h3333_4444);
        check_val("s_d_resp_off", {63'd0, data_mem_resp}, 64'd0);
        tick();
        inst_mem_read = 1'b0;
        pmem_resp     = 1'b0;

        // ---- data write (read also high: write wins), 5-cycle delay ----
        tick();
        data_mem_read    = 1'b1;
        data_mem_write   = 1'b1;
        data_mem_address = 32'h0000_3000;
        data_mem_wdata   = 32'hDEAD_BEEF;
        data_mem_mbe     = 4'b0011;
        tick();
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                data_mem_address = 32'h0000_4000;
                data_mem_wdata   = 32'h0;
                data_mem_mbe     = 4'b1111;
            end
            sample();
            check_val($sformatf("w_write_c%0d", c), {63'd0, pmem_write}, 64'd1);
            check_val($sformatf("w_read_c%0d", c),  {63'd0, pmem_read}, 64'd0);
            check_val($sformatf("w_addr_c%0d", c),  {32'd0, pmem_address}, 64'h3000);
            check_val($sformatf("w_wdata_c%0d", c), {32'd0, pmem_wdata}, 64'hDEAD_BEEF);
            check_val($sformatf("w_mbe_c%0d", c),   {60'd0, pmem_mbe}, 64'h3);
            check_val($sformatf("w_resp_c%0d", c),  {63'd0, data_mem_resp}, 64'd0);
            tick();
        end
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h5555_6666;
        sample();
        check_val("w_resp",     {63'd0, data_mem_resp}, 64'd1);
        check_val("w_addr_end", {32'd0, pmem_address}, 64'h3000);
        check_val("w_i_resp",   {63'd0, inst_mem_resp}, 64'd0);
        tick();
        data_mem_read  = 1'b0;
        data_mem_write = 1'b0;
        pmem_resp      = 1'b0;
        sample();
        check_val("w_after_resp",  {63'd0, data_mem_resp}, 64'd0);
        check_val("w_after_write", {63'd0, pmem_write}, 64'd0);

        // ---- requester drops request mid-transaction: still completes ----
        tick();
        inst_mem_read    = 1'b1;
        inst_mem_address = 32'h0000_0300;
        tick();
        inst_mem_read = 1'b0;
        sample();
        check_val("drop_still_read", {63'd0, pmem_read}, 64'd1);
        check_val("drop_addr",       {32'd0, pmem_address}, 64'h300);
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h7777_8888;
        sample();
        check_val("drop_resp", {63'd0, inst_mem_resp}, 64'd1);
        tick();
        pmem_resp = 1'b0;

        // ---- reset mid-transaction, late pmem_resp ignored ----
        tick();
        inst_mem_read    = 1'b1;
        inst_mem_address = 32'h0000_0200;
        tick();
        sample();
        check_val("r_pre_read", {63'd0, pmem_read}, 64'd1);
        tick();
        rst           = 1'b1;
        inst_mem_read = 1'b0;
        tick();
        rst = 1'b0;
        sample();
        check_val("r_read_dropped", {63'd0, pmem_read}, 64'd0);
        check_val("r_addr_clear",   {32'd0, pmem_address}, 64'd0);
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h9999_AAAA;
        sample();
        check_val("r_late_i_resp", {63'd0, inst_mem_resp}, 64'd0);
        check_val("r_late_d_resp", {63'd0, data_mem_resp}, 64'd0);
        tick();
        pmem_resp = 1'b0;

        // ---- stray pmem_resp in IDLE ----
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = 32'hCAFE_F00D;
        sample();
        check_val("stray_i_resp",  {63'd0, inst_mem_resp}, 64'd0);
        check_val("stray_d_resp",  {63'd0, data_mem_resp}, 64'd0);
        check_val("stray_i_rdata", {32'd0, inst_mem_rdata}, 64'd0);
        check_val("stray_read",    {63'd0, pmem_read}, 64'd0);
        tick();
        pmem_resp = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_mem_arbiter
